// File: rtl/pool_pkg.sv
// Shared types and constants for the pooling datapath.
package pool_pkg;
   localparam int         POOL_DW  = 8;
   localparam logic [4:0] PAD_ADDR = 5'd31;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} pool_state_e;
endpackage

// File: rtl/pool_datapath_if.sv
// Controller/next-layer facing bus of the pooling datapath.
interface pool_datapath_if
   import pool_pkg::*;
   #(parameter int DW = POOL_DW) ();
   logic                 load_en;
   logic [4:0]           load_addr;
   logic [DW-1:0]        load_data;
   logic                 start_pool;
   logic [3:0][4:0]      address;
   logic                 in_pipe_en;
   logic                 max_avg;
   logic                 done_in;
   logic [3:0]           out_rd_addr;
   logic [DW-1:0]        out_rd_data;
   logic [3:0]           result_count;
   logic                 busy;
   logic                 pool_done;
   logic                 err;

   modport slave (
      input  load_en, load_addr, load_data, start_pool, address, in_pipe_en,
             max_avg, done_in, out_rd_addr,
      output out_rd_data, result_count, busy, pool_done, err
   );
   modport master (
      output load_en, load_addr, load_data, start_pool, address, in_pipe_en,
             max_avg, done_in, out_rd_addr,
      input  out_rd_data, result_count, busy, pool_done, err
   );
endinterface

// File: rtl/pool_reduce4.sv
// Combinational 4-operand max/average reduce; padded operands are masked out.
module pool_reduce4
   import pool_pkg::*;
   #(parameter int DW = POOL_DW) (
   input  logic [3:0][DW-1:0] ops_i,
   input  logic [3:0]         mask_i,
   input  logic               max_avg_i,
   output logic [DW-1:0]      res_o,
   output logic               deg_o
);
   logic [DW+1:0] sum;
   logic [DW-1:0] mx;
   logic [2:0]    n;

   always_comb begin
      sum   = '0;
      mx    = '0;
      n     = '0;
      res_o = '0;
      deg_o = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (mask_i[i]) begin
            sum = sum + (DW+2)'(ops_i[i]);
            if (ops_i[i] > mx) mx = ops_i[i];
            n = n + 3'd1;
         end
      end
      // An empty window is degenerate in either mode; n=3 only matters for averaging.
      if (max_avg_i) begin
         res_o = mx;
         deg_o = (n == 3'd0);
      end else begin
         case (n)
            3'd4:    res_o = DW'(sum >> 2);
            3'd2:    res_o = DW'(sum >> 1);
            3'd1:    res_o = DW'(sum);
            3'd3: begin
               res_o = DW'(sum >> 2);
               deg_o = 1'b1;
            end
            default: deg_o = 1'b1;
         endcase
      end
   end
endmodule

// File: rtl/pool_datapath.sv
// Pooling datapath: input buffer, 3-stage window reduce, sequential output buffer.
module pool_datapath
   import pool_pkg::*;
   #(parameter int DW        = POOL_DW,
     parameter int OUT_DEPTH = 9) (
   input logic             clk,
   input logic             nrst,
   pool_datapath_if.slave  bus
);
   localparam logic [3:0] DEPTH_C = 4'(OUT_DEPTH);

   logic [DW-1:0]        ibuf_q [31];
   logic [DW-1:0]        obuf_q [OUT_DEPTH];
   pool_state_e          state_q, state_d;
   logic [2:1]           vld_pipe_q, vld_pipe_d;
   logic [3:0][DW-1:0]   rd_ops, s1_ops_q;
   logic [3:0]           s1_mask_q;
   logic                 s1_max_q;
   logic [DW-1:0]        s2_res_q, red_res, rd_q;
   logic                 red_deg, err_q, err_d, accept, wr_en;
   logic [3:0]           cnt_q, cnt_d;

   assign accept = bus.in_pipe_en && (state_q == RUN) && !bus.start_pool;
   assign wr_en  = vld_pipe_q[2] && !bus.start_pool && (cnt_q < DEPTH_C);

   // Entry 31 is the pad slot: never stored, always reads as zero.
   always_comb begin
      rd_ops = '0;
      for (int i = 0; i < 4; i++)
         if (bus.address[i] != PAD_ADDR) rd_ops[i] = ibuf_q[bus.address[i]];
   end

   always_ff @(posedge clk) begin
      if (bus.load_en && bus.load_addr != PAD_ADDR) ibuf_q[bus.load_addr] <= bus.load_data;
      if (accept) begin
         s1_ops_q <= rd_ops;
         for (int i = 0; i < 4; i++) s1_mask_q[i] <= (bus.address[i] != PAD_ADDR);
         s1_max_q <= bus.max_avg;
      end
      if (vld_pipe_q[1]) s2_res_q <= red_res;
      if (wr_en) obuf_q[cnt_q] <= s2_res_q;
   end

   pool_reduce4 #(.DW(DW)) u_reduce (
      .ops_i     (s1_ops_q),
      .mask_i    (s1_mask_q),
      .max_avg_i (s1_max_q),
      .res_o     (red_res),
      .deg_o     (red_deg)
   );

   always_comb begin
      state_d    = state_q;
      vld_pipe_d = {vld_pipe_q[1], accept};
      cnt_d      = cnt_q;
      err_d      = err_q;
      if (vld_pipe_q[1] && red_deg) err_d = 1'b1;
      if (vld_pipe_q[2]) begin
         if (cnt_q < DEPTH_C) cnt_d = cnt_q + 4'd1;
         else                 err_d = 1'b1;
      end
      case (state_q)
         IDLE:    state_d = IDLE;
         RUN:     if (bus.done_in) state_d = DRAIN;
         // Leave once the pipeline empties at this edge, so DONE sees the final count.
         DRAIN:   if (vld_pipe_d == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (bus.start_pool) begin
         state_d    = RUN;
         vld_pipe_d = '0;
         cnt_d      = '0;
         err_d      = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         vld_pipe_q <= '0;
         cnt_q      <= '0;
         err_q      <= 1'b0;
         rd_q       <= '0;
      end else begin
         state_q    <= state_d;
         vld_pipe_q <= vld_pipe_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         rd_q       <= (bus.out_rd_addr < DEPTH_C) ? obuf_q[bus.out_rd_addr] : '0;
      end
   end

   assign bus.out_rd_data  = rd_q;
   assign bus.result_count = cnt_q;
   assign bus.busy         = (state_q != IDLE);
   assign bus.pool_done    = (state_q == DONE);
   assign bus.err          = err_q;
endmodule

// File: tb/tb_pool_datapath.sv
// Scoreboard bench: stimulus pushes model results, a monitor reads back each write.
module tb_pool_datapath;
   localparam int DW = 8;
   localparam int OD = 9;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   pool_datapath_if #(.DW(DW)) bus ();
   pool_datapath #(.DW(DW), .OUT_DEPTH(OD)) dut (.clk(clk), .nrst(nrst), .bus(bus));

   int            n_chk = 0;
   int            n_err = 0;
   logic [DW-1:0] mem_m [32];
   logic [DW-1:0] exp_q [$];
   int            m_cnt = 0;
   bit            m_err = 1'b0;
   bit            probe_req = 1'b0;
   bit            rd_pend = 1'b0;

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [4:0] rnd_addr();
      if ($urandom_range(0, 3) == 0) return 5'd31;
      return 5'($urandom_range(0, 30));
   endfunction

   // Reference: pool the non-pad values of the window by plain arithmetic.
   task automatic window(input logic [3:0][4:0] a, input bit mx);
      int s = 0, n = 0, m = 0, r;
      for (int i = 0; i < 4; i++)
         if (a[i] != 5'd31) begin
            n++;
            s += int'(mem_m[a[i]]);
            if (int'(mem_m[a[i]]) > m) m = int'(mem_m[a[i]]);
         end
      if (mx)          r = m;
      else if (n == 0) r = 0;
      else if (n == 3) r = s / 4;
      else             r = s / n;
      if (n == 0 || (!mx && n == 3)) m_err = 1'b1;
      if (m_cnt < OD) begin
         exp_q.push_back(8'(r));
         m_cnt++;
      end else m_err = 1'b1;
      bus.address    = a;
      bus.max_avg    = mx;
      bus.in_pipe_en = 1'b1;
   endtask

   task automatic issue(input logic [3:0][4:0] a, input bit mx);
      window(a, mx);
      @(negedge clk);
      bus.in_pipe_en = 1'b0;
   endtask

   task automatic load(input int a, input int d);
      bus.load_en   = 1'b1;
      bus.load_addr = 5'(a);
      bus.load_data = 8'(d);
      if (a != 31) mem_m[a] = 8'(d);
      @(negedge clk);
      bus.load_en = 1'b0;
   endtask

   task automatic start();
      bus.start_pool = 1'b1;
      exp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      @(negedge clk);
      bus.start_pool = 1'b0;
   endtask

   // Called in the cycle done_in is driven; cycle i=1 is the one after.
   task automatic wait_done();
      int pulses = 0, first = -1;
      bit prev = 1'b0;
      for (int i = 1; i <= 14; i++) begin
         @(negedge clk);
         if (i == 1) begin
            bus.done_in    = 1'b0;
            bus.in_pipe_en = 1'b0;
         end
         if (prev) chk("busy_after_done", int'(bus.busy), 0);
         prev = bus.pool_done;
         if (bus.pool_done) begin
            pulses++;
            if (first < 0) first = i;
         end
      end
      chk("pool_done_pulses", pulses, 1);
      if (pulses > 0) chk("pool_done_within_3", int'(first <= 3), 1);
      chk("final_count", int'(bus.result_count), m_cnt);
      chk("final_err", int'(bus.err), int'(m_err));
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   // Monitor: every result_count step pops one expected value and reads it back.
   initial begin
      int last = 0;
      logic [DW-1:0] e = '0;
      bus.out_rd_addr = '0;
      forever begin
         @(negedge clk);
         if (rd_pend) chk("rd_data", int'(bus.out_rd_data), int'(e));
         rd_pend = 1'b0;
         if (bus.result_count == 4'd0) last = 0;
         else if (int'(bus.result_count) == last + 1) begin
            if (exp_q.size() == 0) begin
               n_chk++;
               n_err++;
               $display("FAIL unexpected_write: count %0d with no result pending", bus.result_count);
            end else begin
               e = exp_q.pop_front();
               bus.out_rd_addr = 4'(last);
               rd_pend = 1'b1;
            end
            last++;
         end else if (int'(bus.result_count) != last) begin
            chk("count_step", int'(bus.result_count), last + 1);
            last = int'(bus.result_count);
         end else if (probe_req) begin
            bus.out_rd_addr = 4'(OD + $urandom_range(0, 15 - OD));
            e = '0;
            rd_pend = 1'b1;
            probe_req = 1'b0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0][4:0] a;
      bus.load_en = 0; bus.load_addr = '0; bus.load_data = '0; bus.start_pool = 0;
      bus.address = '0; bus.in_pipe_en = 0; bus.max_avg = 0; bus.done_in = 0;
      for (int i = 0; i < 32; i++) mem_m[i] = '0;
      repeat (2) @(negedge clk);
      chk("rst_count", int'(bus.result_count), 0);
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.pool_done), 0);
      chk("rst_err", int'(bus.err), 0);
      chk("rst_rd_data", int'(bus.out_rd_data), 0);
      nrst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 31; i++) load(i, $urandom_range(0, 255));
      load(31, 255);
      load(0, 3); load(1, 9); load(5, 4); load(6, 7);

      // Directed windows, with an exact latency check on the first.
      start();
      chk("busy_run", int'(bus.busy), 1);
      window({5'd6, 5'd5, 5'd1, 5'd0}, 1'b1);
      @(negedge clk);
      bus.in_pipe_en = 1'b0;
      @(negedge clk);
      chk("lat_t2_count", int'(bus.result_count), 0);
      @(negedge clk);
      chk("lat_t3_count", int'(bus.result_count), 1);
      chk("max_full_err", int'(bus.err), 0);
      issue({5'd6, 5'd5, 5'd1, 5'd0}, 1'b0);
      issue({5'd31, 5'd31, 5'd1, 5'd0}, 1'b0);
      issue({5'd31, 5'd31, 5'd31, 5'd0}, 1'b1);
      issue({5'd31, 5'd31, 5'd31, 5'd31}, 1'b0);
      repeat (4) @(negedge clk);
      chk("all_pad_err", int'(bus.err), 1);
      bus.done_in = 1'b1;
      wait_done();
      probe_req = 1'b1;
      repeat (3) @(negedge clk);

      // Streaming overflow: 10 back-to-back windows, done_in with the last.
      for (int i = 0; i < 12; i++) load($urandom_range(0, 31), $urandom_range(0, 255));
      start();
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < 4; i++) a[i] = rnd_addr();
         window(a, 1'($urandom_range(0, 1)));
         if (k == 9) bus.done_in = 1'b1;
         else @(negedge clk);
      end
      wait_done();
      chk("overflow_count", int'(bus.result_count), OD);
      chk("overflow_err", int'(bus.err), 1);

      // Random runs with gaps.
      for (int r = 0; r < 4; r++) begin
         int nw = $urandom_range(1, 8);
         start();
         for (int k = 0; k < nw; k++) begin
            for (int i = 0; i < 4; i++) a[i] = rnd_addr();
            issue(a, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
         bus.done_in = 1'b1;
         wait_done();
      end

      // Restart with two windows in flight.
      start();
      window({5'd6, 5'd5, 5'd1, 5'd0}, 1'b1);
      @(negedge clk);
      window({5'd6, 5'd5, 5'd1, 5'd0}, 1'b0);
      @(negedge clk);
      bus.in_pipe_en = 1'b0;
      start();
      for (int i = 0; i < 4; i++) begin
         chk("restart_count", int'(bus.result_count), 0);
         @(negedge clk);
      end
      chk("restart_busy", int'(bus.busy), 1);
      issue({5'd31, 5'd6, 5'd31, 5'd5}, 1'b0);
      bus.done_in = 1'b1;
      wait_done();
      chk("restart_one_result", int'(bus.result_count), 1);

      // Asynchronous reset mid-stream.
      start();
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 4; i++) a[i] = 5'($urandom_range(0, 30));
         window(a, 1'b1);
         @(negedge clk);
      end
      bus.in_pipe_en = 1'b0;
      #2 nrst = 1'b0;
      #1;
      rd_pend = 1'b0;
      exp_q.delete();
      m_cnt = 0;
      m_err = 1'b0;
      chk("arst_count", int'(bus.result_count), 0);
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.pool_done), 0);
      chk("arst_err", int'(bus.err), 0);
      chk("arst_rd_data", int'(bus.out_rd_data), 0);
      @(negedge clk);
      nrst = 1'b1;
      bus.address = {5'd6, 5'd5, 5'd1, 5'd0};
      bus.in_pipe_en = 1'b1;
      repeat (5) @(negedge clk);
      bus.in_pipe_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_ignore_count", int'(bus.result_count), 0);
      chk("idle_ignore_busy", int'(bus.busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/pool_datapath.md
# pool_datapath

Pooling datapath directly downstream of the pooling controller. It holds a 32-entry input feature-map buffer and reads four window operands per `in_pipe_en` at controller-supplied addresses. It reduces each window to its max or average over a 3-stage pipeline and writes the results sequentially into a 9-entry output buffer, which the next layer reads.

## Interface
- `DW`, 8: unsigned pixel width
- `OUT_DEPTH`, 9: output buffer entries (5x5 input with 2x2 windows gives 9 results)
- `clk`  in  1  clock
- `nrst`  in  1  reset, asynchronous, active-low
- `load_en`  in  1  write strobe for the input buffer
- `load_addr`  in  5  input buffer write address
- `load_data`  in  DW  input buffer write data
- `start_pool`  in  1  pulse: clear results, enter RUN
- `address`  in  [3:0][4:0]  window operand addresses; 5'd31 = pad
- `in_pipe_en`  in  1  window valid this cycle
- `max_avg`  in  1  1 = max, 0 = average; sampled with `in_pipe_en`
- `done_in`  in  1  controller finished issuing windows
- `out_rd_addr`  in  4  output buffer read address
- `out_rd_data`  out  DW  registered read data
- `result_count`  out  4  results written since `start_pool`
- `busy`  out  1  state != IDLE
- `pool_done`  out  1  one-cycle pulse, all results written
- `err`  out  1  sticky: degenerate window or overflow

## Operation
- Input buffer: 32 x DW.
  - Written when `load_en`; writes to address 31 are ignored.
  - Entry 31 always reads as 0 and is never counted.
  - Read-before-write: a same-cycle read at the written address returns the old value.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on `start_pool`. This clears `result_count`, `err` and pipeline valids.
  - RUN -> DRAIN on `done_in`.
  - DRAIN -> DONE when stage-1 and stage-2 valids are both 0.
  - DONE -> IDLE unconditionally.
  - `start_pool` in RUN, DRAIN or DONE restarts to RUN with the same clears, and flushes in-flight windows. It wins over a simultaneous `in_pipe_en` or `done_in`.
- `in_pipe_en` is accepted only in RUN and ignored elsewhere. An `in_pipe_en` in the same cycle as `done_in` is accepted.
- Stage 1 (edge after accept) registers:
  - four operands
  - valid mask: bit i = `address[i]` != 31
  - `max_avg`
- Stage 2 (combinational reduce of stage 1, then registered):
  - Max: unsigned max over valid operands.
  - Average: sum over valid operands (DW+2 bits), divided according to n = popcount(mask):
    - n=4: sum>>2
    - n=2: sum>>1
    - n=1: sum
    - n=3: sum>>2, sets `err`
    - n=0: result 0, sets `err`
  - Result is truncated to DW bits.
- Stage 3 (write edge): result written at index `result_count`, which then increments.
  - At `result_count` == OUT_DEPTH the write is dropped, the count holds and `err` is set.
- Output read: `out_rd_data` <= buffer[`out_rd_addr`] every edge. Addresses >= OUT_DEPTH return 0.

## Timing
- Reset values: `out_rd_data` 0, `result_count` 0, `busy` 0, `pool_done` 0, `err` 0, state IDLE, pipeline valids 0. Buffer contents are not reset.
- Reset mid-operation: all of the above take effect immediately, asynchronously; in-flight windows are lost.
- Latency: with `in_pipe_en` in cycle T, `result_count` shows +1 in cycle T+3. The data is readable via `out_rd_data` in cycle T+4 when `out_rd_addr` is presented in T+3.
- Throughput: one window per cycle; back-to-back `in_pipe_en` is legal.
- `pool_done` is high for exactly the DONE cycle, after the final write is visible in `result_count`. With `done_in` in cycle D and the last window accepted at or before D, `pool_done` asserts no later than D+3.

## Structure
- Package `pool_pkg`:
  - `PAD_ADDR` = 5'd31
  - `pool_state_e` enum (IDLE, RUN, DRAIN, DONE)
  - default `DW`
- Sub-module `pool_reduce4`: combinational; operands, mask and `max_avg` in; result and degenerate flag out. Used for stage 2.

## Test plan
- Max, full window: load entries 0,1,5,6 = 3,9,4,7; `max_avg`=1, `address`={6,5,1,0}, one `in_pipe_en` -> `result_count`=1 at T+3, buffer[0]=9, `err`=0.
- Average, full window: same data, `max_avg`=0 -> buffer[0]=5 (23>>2).
- Padded windows: `address`={31,31,1,0}, avg -> 6; `address`={31,31,31,0}, max -> 3; `address`={31,31,31,31} -> 0 and `err`=1.
- Streaming, overflow and drain: 10 back-to-back windows, then `done_in` -> 9 results written, 10th dropped, `err`=1, `pool_done` single pulse, `busy` falls the following cycle.
- Restart: `start_pool` with two windows in flight -> `result_count`=0, no stale writes; the next window lands at index 0.
- Async reset: `nrst` low mid-stream -> all outputs 0 in the same cycle; state IDLE; `in_pipe_en` ignored until the next `start_pool`.
